// File: rtl/pe_pkg.sv
// Shared constants and result type for the PE output normalizer.
package pe_pkg;

   localparam int WIDTH    = 49;
   localparam int EXP_W    = 10;
   localparam int MAN_W    = 23;
   localparam int FRAC_POS = 46;
   localparam int EXPI_W   = EXP_W + 2;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
      logic             zero;
      logic             ovf;
      logic             udf;
   } norm_t;

endpackage

// File: rtl/pe_lzc.sv
// Combinational leading-zero counter; lz saturates at WIDTH-1 for an all-zero input.
module pe_lzc #(
   parameter int WIDTH = 49
) (
   input  logic [WIDTH-1:0]         mag,
   output logic [$clog2(WIDTH)-1:0] lz,
   output logic                     all_zero
);

   localparam int LZ_W = $clog2(WIDTH);

   // Scan upward so the highest set bit is the last one to win.
   always_comb begin
      lz       = LZ_W'(WIDTH - 1);
      all_zero = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         if (mag[i]) begin
            lz       = LZ_W'(WIDTH - 1 - i);
            all_zero = 1'b0;
         end
      end
   end

endmodule

// File: rtl/pe_normalize.sv
// Post-accumulation normalizer: signed aligned sum -> sign / biased exponent / RNE fraction,
// three register stages with valid/ready flow control.
module pe_normalize #(
   parameter int WIDTH    = pe_pkg::WIDTH,
   parameter int EXP_W    = pe_pkg::EXP_W,
   parameter int MAN_W    = pe_pkg::MAN_W,
   parameter int FRAC_POS = pe_pkg::FRAC_POS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [EXP_W-1:0] in_exp,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [MAN_W-1:0] out_man,
   output logic             out_zero,
   output logic             out_ovf,
   output logic             out_udf
);

   import pe_pkg::*;

   localparam int LZ_W = $clog2(WIDTH);
   localparam int GRD  = WIDTH - 2 - MAN_W;
   localparam logic signed [EXPI_W-1:0] EXP_OFS = EXPI_W'(WIDTH - 1 - FRAC_POS);
   localparam logic signed [EXPI_W-1:0] EXP_MAX = EXPI_W'((1 << EXP_W) - 1);
   localparam logic signed [EXPI_W-1:0] EXP_MIN = '0;

   logic vld_p0, vld_p1, vld_p2;
   logic ld_p0, ld_p1, ld_p2;

   logic             sign_p0, zero_p0;
   logic [WIDTH-1:0] mag_p0;
   logic [EXP_W-1:0] exp_p0;

   logic                     sign_p1, zero_p1;
   logic [WIDTH-1:0]         shf_p1;
   logic signed [EXPI_W-1:0] exp_p1;

   norm_t res_p2;

   logic signed [WIDTH-1:0]  din_c;
   logic [WIDTH-1:0]         mag_c, shf_c;
   logic [LZ_W-1:0]          lz_c;
   logic                     lz_zero;
   logic signed [EXPI_W-1:0] exp_c, exp_r_c;
   logic [MAN_W:0]           rnd_c;
   norm_t                    res_c;

   // Returns {carry, fraction}; a carry leaves the fraction at zero.
   function automatic logic [MAN_W:0] round_rne(input logic [WIDTH-1:0] shf);
      logic [MAN_W-1:0] f;
      logic             g, s;
      f = shf[WIDTH-2 -: MAN_W];
      g = shf[GRD];
      s = |shf[GRD-1:0];
      return {1'b0, f} + {{MAN_W{1'b0}}, g & (s | f[0])};
   endfunction

   function automatic norm_t saturate(input logic sign, input logic zero,
                                      input logic signed [EXPI_W-1:0] e,
                                      input logic [MAN_W-1:0] man);
      norm_t o;
      o = '0;
      if (zero) begin
         o.zero = 1'b1;
      end else if (e >= EXP_MAX) begin
         o.sign = sign;
         o.exp  = '1;
         o.ovf  = 1'b1;
      end else if (e <= EXP_MIN) begin
         o.sign = sign;
         o.udf  = 1'b1;
      end else begin
         o.sign = sign;
         o.exp  = e[EXP_W-1:0];
         o.man  = man;
      end
      return o;
   endfunction

   // A stage loads when empty or when its content moves on this cycle.
   assign ld_p2    = !vld_p2 | out_ready;
   assign ld_p1    = !vld_p1 | ld_p2;
   assign ld_p0    = !vld_p0 | ld_p1;
   assign in_ready = ld_p0;

   // ---- S1: sign / magnitude / zero ----
   assign din_c = in_data;
   assign mag_c = din_c[WIDTH-1] ? WIDTH'(-din_c) : WIDTH'(din_c);

   // ---- S2: leading-zero count and left-justify ----
   pe_lzc #(.WIDTH(WIDTH)) u_lzc (
      .mag      (mag_p0),
      .lz       (lz_c),
      .all_zero (lz_zero)
   );

   assign shf_c = lz_zero ? '0 : (mag_p0 << lz_c);
   assign exp_c = $signed({2'b00, exp_p0}) + EXP_OFS
                - $signed({{(EXPI_W-LZ_W){1'b0}}, lz_c});

   // ---- S3: round and saturate ----
   always_comb begin
      rnd_c   = round_rne(shf_p1);
      exp_r_c = exp_p1 + $signed({{(EXPI_W-1){1'b0}}, rnd_c[MAN_W]});
      res_c   = saturate(sign_p1, zero_p1, exp_r_c, rnd_c[MAN_W-1:0]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         res_p2 <= '0;
      end else begin
         if (ld_p0) vld_p0 <= in_valid;
         if (ld_p1) vld_p1 <= vld_p0;
         if (ld_p2) vld_p2 <= vld_p1;
         if (ld_p2 && vld_p1) res_p2 <= res_c;
      end
   end

   always_ff @(posedge clk) begin
      if (ld_p0 && in_valid) begin
         sign_p0 <= in_data[WIDTH-1];
         mag_p0  <= mag_c;
         exp_p0  <= in_exp;
         zero_p0 <= (in_data == '0);
      end
      if (ld_p1 && vld_p0) begin
         sign_p1 <= sign_p0;
         shf_p1  <= shf_c;
         exp_p1  <= exp_c;
         zero_p1 <= zero_p0;
      end
   end

   assign out_valid = vld_p2;
   assign out_sign  = res_p2.sign;
   assign out_exp   = res_p2.exp;
   assign out_man   = res_p2.man;
   assign out_zero  = res_p2.zero;
   assign out_ovf   = res_p2.ovf;
   assign out_udf   = res_p2.udf;

endmodule

// File: tb/tb_pe_normalize.sv
// Self-checking bench for pe_normalize: directed corner values plus random streams
// compared against an arithmetic reference model.
module tb_pe_normalize;

   localparam int W = 49;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic [9:0]    in_exp = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_sign, out_zero, out_ovf, out_udf;
   logic [9:0]    out_exp;
   logic [22:0]   out_man;
   logic [36:0]   dut_res;

   int n_cmp = 0;
   int n_bad = 0;

   pe_normalize dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_exp    (in_exp),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sign  (out_sign),
      .out_exp   (out_exp),
      .out_man   (out_man),
      .out_zero  (out_zero),
      .out_ovf   (out_ovf),
      .out_udf   (out_udf)
   );

   always #5 clk = ~clk;

   assign dut_res = {out_sign, out_exp, out_man, out_zero, out_ovf, out_udf};

   // Value = d * 2^(e-46); find the binary point of |d|, round the 24-bit significand
   // to nearest-even by remainder comparison, then apply the exponent limits.
   function automatic logic [36:0] model(input logic [W-1:0] d, input logic [9:0] e);
      longint unsigned mag, q, rem, half;
      int p, ex, sh;
      logic sg;
      sg = d[W-1];
      if (d == '0) return {1'b0, 10'd0, 23'd0, 3'b100};
      mag = sg ? ((64'd1 << W) - {15'd0, d}) : {15'd0, d};
      p = 0;
      for (int i = 0; i < 64; i++) if (mag[i]) p = i;
      ex = int'(e) + p - 46;
      if (p > 23) begin
         sh   = p - 23;
         q    = mag >> sh;
         rem  = mag & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      end else begin
         q = mag << (23 - p);
      end
      if (q == (64'd1 << 24)) begin
         q  = q >> 1;
         ex = ex + 1;
      end
      if (ex >= 1023) return {sg, 10'h3FF, 23'd0, 3'b010};
      if (ex <= 0)    return {sg, 10'd0, 23'd0, 3'b001};
      return {sg, 10'(ex), 23'(q - (64'd1 << 23)), 3'b000};
   endfunction

   task automatic rand_beat(output logic [W-1:0] d, output logic [9:0] e);
      logic [63:0] r;
      r = {$urandom, $urandom};
      d = W'(r >> $urandom_range(15, 63));
      if ($urandom_range(0, 1) == 1) d = -d;
      if ($urandom_range(0, 15) == 0) begin
         d = '0;
         d[W-1] = 1'b1;
      end
      case ($urandom_range(0, 9))
         0:       e = 10'($urandom_range(0, 50));
         1:       e = 10'($urandom_range(990, 1023));
         default: e = 10'($urandom_range(60, 960));
      endcase
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if (dut_res !== 37'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h want 0", dut_res);
      end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      longint      dv[9];
      int          de[9];
      logic [36:0] dx[9];
      int          lat;
      logic        seen;
      dv = '{longint'(1) << 46, -(longint'(3) << 45), longint'(1) << 48,
             (longint'(1) << 46) | (longint'(1) << 22),
             (longint'(1) << 46) | (longint'(1) << 23) | (longint'(1) << 22),
             (longint'(1) << 47) - 1, longint'(1) << 47, longint'(1), longint'(0)};
      de = '{127, 127, 127, 127, 127, 127, 1022, 0, 55};
      dx = '{{1'b0, 10'd127, 23'd0,       3'b000},
             {1'b1, 10'd127, 23'h400000,  3'b000},
             {1'b1, 10'd129, 23'd0,       3'b000},
             {1'b0, 10'd127, 23'd0,       3'b000},
             {1'b0, 10'd127, 23'd2,       3'b000},
             {1'b0, 10'd128, 23'd0,       3'b000},
             {1'b0, 10'h3FF, 23'd0,       3'b010},
             {1'b0, 10'd0,   23'd0,       3'b001},
             {1'b0, 10'd0,   23'd0,       3'b100}};
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         in_valid  = 1'b1;
         in_data   = W'(dv[i]);
         in_exp    = 10'(de[i]);
         @(negedge clk);
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat  = 0;
         seen = 1'b0;
         while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) seen = 1'b1;
         end
         n_cmp++;
         if (!seen || lat != 3) begin
            n_bad++;
            $display("FAIL dir%0d_latency: got %0d cycles want 3", i, lat);
         end
         n_cmp++;
         if (dut_res !== dx[i]) begin
            n_bad++;
            $display("FAIL dir%0d_result: got %h want %h", i, dut_res, dx[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [36:0] q[$];
      logic [36:0] x;
      logic [W-1:0] d;
      logic [9:0]  e;
      int sent = 0, got = 0, cyc = 0, stall = 0;
      logic acc;
      localparam int N = 24;
      @(posedge clk); #1;
      out_ready = 1'b1;
      rand_beat(d, e);
      in_valid = 1'b1; in_data = d; in_exp = e;
      while (got < N && cyc < 200) begin
         @(negedge clk);
         cyc++;
         acc = in_valid && in_ready;
         if (in_valid && !in_ready) stall++;
         if (acc) begin
            q.push_back(model(in_data, in_exp));
            sent++;
         end
         if (out_valid && out_ready) begin
            got++;
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL b2b_extra_beat: got %h want none", dut_res);
            end else begin
               x = q.pop_front();
               if (dut_res !== x) begin
                  n_bad++;
                  $display("FAIL b2b_beat%0d: got %h want %h", got, dut_res, x);
               end
            end
         end
         @(posedge clk); #1;
         if (acc) begin
            if (sent < N) begin
               rand_beat(d, e);
               in_data = d; in_exp = e;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      n_cmp++;
      if (cyc != N + 3 || stall != 0) begin
         n_bad++;
         $display("FAIL b2b_throughput: got %0d cycles %0d stalls want %0d cycles 0 stalls",
                  cyc, stall, N + 3);
      end
   endtask

   task automatic test_backpressure();
      logic [36:0] q[$];
      logic [36:0] x, prev_res;
      logic [W-1:0] d;
      logic [9:0]  e;
      logic acc, prev_stall;
      int sent = 0, got = 0, cyc = 0;
      localparam int N = 10;
      prev_stall = 1'b0;
      prev_res   = '0;
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      rand_beat(d, e);
      in_valid = 1'b1; in_data = d; in_exp = e;
      while (got < N && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (prev_stall) begin
            n_cmp++;
            if (out_valid !== 1'b1 || dut_res !== prev_res) begin
               n_bad++;
               $display("FAIL bp_stall_hold: got v=%b %h want v=1 %h", out_valid, dut_res, prev_res);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_res   = dut_res;
         acc = in_valid && in_ready;
         if (acc) begin
            q.push_back(model(in_data, in_exp));
            sent++;
         end
         if (out_valid && out_ready) begin
            got++;
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL bp_extra_beat: got %h want none", dut_res);
            end else begin
               x = q.pop_front();
               if (dut_res !== x) begin
                  n_bad++;
                  $display("FAIL bp_beat%0d: got %h want %h", got, dut_res, x);
               end
            end
         end
         @(posedge clk); #1;
         out_ready = 1'($urandom_range(0, 1));
         if (acc) begin
            if (sent < N) begin
               rand_beat(d, e);
               in_data = d; in_exp = e;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_cmp++;
      if (got != N || q.size() != 0) begin
         n_bad++;
         $display("FAIL bp_count: got %0d beats %0d left want %0d beats 0 left", got, q.size(), N);
      end
   endtask

   task automatic test_full();
      logic [36:0] q[$];
      logic [36:0] x;
      logic [W-1:0] d;
      logic [9:0]  e;
      int acc_n = 0, got = 0, cyc = 0;
      logic acc;
      @(posedge clk); #1;
      out_ready = 1'b0;
      rand_beat(d, e);
      in_valid = 1'b1; in_data = d; in_exp = e;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) begin
            q.push_back(model(in_data, in_exp));
            acc_n++;
         end
         @(posedge clk); #1;
         if (acc) begin
            rand_beat(d, e);
            in_data = d; in_exp = e;
         end
      end
      n_cmp++;
      if (acc_n != 3) begin
         n_bad++;
         $display("FAIL full_accept_count: got %0d want 3", acc_n);
      end
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL full_in_ready: got in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (got < acc_n && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (out_valid && out_ready) begin
            got++;
            x = q.pop_front();
            n_cmp++;
            if (dut_res !== x) begin
               n_bad++;
               $display("FAIL full_drain%0d: got %h want %h", got, dut_res, x);
            end
         end
      end
      n_cmp++;
      if (got != acc_n) begin
         n_bad++;
         $display("FAIL full_drain_count: got %0d want %0d", got, acc_n);
      end
   endtask

   task automatic test_reset_inflight();
      logic [36:0] x;
      logic [W-1:0] d;
      logic [9:0]  e;
      int acc_n = 0, lat = 0, early = 0;
      logic seen;
      @(posedge clk); #1;
      out_ready = 1'b0;
      rand_beat(d, e);
      in_valid = 1'b1; in_data = d; in_exp = e;
      for (int c = 0; c < 8 && acc_n < 3; c++) begin
         @(negedge clk);
         if (in_valid && in_ready) acc_n++;
         @(posedge clk); #1;
         rand_beat(d, e);
         in_data = d; in_exp = e;
      end
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || acc_n != 3) begin
         n_bad++;
         $display("FAIL rsti_loaded: got out_valid=%b accepted=%0d want 1 3", out_valid, acc_n);
      end
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || dut_res !== 37'd0) begin
         n_bad++;
         $display("FAIL rsti_cleared: got v=%b %h want v=0 0", out_valid, dut_res);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      rand_beat(d, e);
      in_valid = 1'b1; in_data = d; in_exp = e;
      x = model(d, e);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rsti_in_ready: got %b want 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = 1'b0;
      while (!seen && lat < 10) begin
         @(negedge clk);
         lat++;
         if (out_valid === 1'b1) begin
            seen = 1'b1;
            if (lat < 3) early++;
         end
      end
      n_cmp++;
      if (!seen || lat != 3 || early != 0) begin
         n_bad++;
         $display("FAIL rsti_latency: got %0d cycles want 3", lat);
      end
      n_cmp++;
      if (dut_res !== x) begin
         n_bad++;
         $display("FAIL rsti_first_beat: got %h want %h", dut_res, x);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rsti_no_stale: got out_valid=%b want 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_full();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pe_normalize.md
Name: pe_normalize

Overview:
- Post-accumulation normalizer for the 16-input PE datapath; the counterpart of the input-side alignment shifters.
- Takes the two's-complement accumulated sum, which is aligned to a common (maximum) exponent, and produces sign / biased exponent / fraction.
- Pipelined in 3 register stages with valid/ready flow control.
- Sits between the adder tree / accumulator and the PE output register.

Parameters:
- WIDTH, 49: width of the signed accumulated sum.
- EXP_W, 10: width of the biased exponent field, in and out.
- MAN_W, 23: output fraction width, hidden bit excluded; requires WIDTH-1 >= MAN_W+2.
- FRAC_POS, 46: bit index of weight 2^0 in in_data. Value = in_data * 2^(in_exp - FRAC_POS), with exponent bias applied downstream.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  WIDTH  signed accumulated sum
- in_exp  in  EXP_W  unsigned common exponent of in_data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_sign  out  1  result sign
- out_exp  out  EXP_W  normalized biased exponent
- out_man  out  MAN_W  rounded fraction
- out_zero  out  1  input was exactly zero
- out_ovf  out  1  exponent overflow, result saturated
- out_udf  out  1  exponent underflow, result flushed to zero

Behaviour:
- Reset:
  - Asynchronous; clears all stage valids and every output register to 0.
  - in_ready is 1 after reset.
  - Reset mid-operation discards all in-flight beats; no partial beat emerges.
- Handshake:
  - A beat transfers on in_valid&in_ready, and on out_valid&out_ready.
  - Stage k loads when it is empty or its content advances this cycle.
  - in_ready = !s1_valid | s1_advance, which is combinational from out_ready through the stage chain.
  - Output fields stay stable while out_valid & !out_ready.
  - Full throughput: one beat per cycle with out_ready held high. Latency is 3 cycles, input accept to out_valid.
  - No beat is dropped or duplicated.
- S1:
  - sign = in_data[WIDTH-1].
  - mag = |in_data| as an unsigned WIDTH-bit value. The most negative input gives mag = 2^(WIDTH-1) with no overflow.
  - zero = (in_data == 0).
  - Register sign, mag, in_exp and zero.
- S2:
  - lz = leading-zero count of mag, range 0..WIDTH-1.
  - shifted = mag << lz, so the leading one lands at bit WIDTH-1.
  - exp_pre = in_exp + (WIDTH-1-lz) - FRAC_POS, computed signed at EXP_W+2 bits.
  - Register shifted, exp_pre, sign and zero.
- S3:
  - Fraction candidate f = shifted[WIDTH-2 -: MAN_W].
  - Guard g = next lower bit; sticky s = OR of all remaining lower bits.
  - Round to nearest, ties to even: increment f when g & (s | f[0]).
  - If the increment carries out of f: f = 0 and exp_pre + 1.
  - Saturation, in priority order:
    - zero: sign 0, exp 0, man 0, out_zero = 1.
    - exp >= 2^EXP_W-1: out_exp all ones, man 0, out_ovf = 1, sign kept.
    - exp <= 0: exp 0, man 0, out_udf = 1, sign kept.
    - otherwise: normal result.
  - At most one of the zero/ovf/udf flags is set.
- No internal state beyond the pipeline registers; no FSM beyond per-stage valid bits.

Decomposition:
- Shared package pe_pkg holds:
  - the default constants WIDTH, EXP_W, MAN_W, FRAC_POS;
  - the signed exponent intermediate width EXP_W+2;
  - a packed struct for the normalized result (sign, exp, man, zero, ovf, udf).
- One sub-module pe_lzc: combinational leading-zero counter.
  - Parameter WIDTH; inputs mag; outputs lz of width $clog2(WIDTH) and all_zero.
  - Reusable by the accumulator path.

Test Plan:
- 1.0: in_data = 1<<46, in_exp = 127 -> sign 0, exp 127, man 0, no flags, out_valid exactly 3 cycles after accept.
- Negative value and extremes:
  - in_data = -(3<<45), exp 127 -> sign 1, exp 127, man 0x400000.
  - in_data = 1<<48 (most negative), exp 127 -> sign 1, exp 129, man 0.
- Rounding:
  - (1<<46)|(1<<22) -> man 0 (tie to even).
  - (1<<46)|(1<<23)|(1<<22) -> man 2.
  - (1<<47)-1, exp 127 -> carry: exp 128, man 0.
- Saturation:
  - in_exp = 1022 with in_data = 1<<47 (+2^47) -> out_ovf, exp 1023, man 0, sign 0.
  - in_exp = 0 with in_data = 1 -> out_udf, exp 0, man 0.
  - in_data = 0 -> out_zero, all fields 0.
- Backpressure: stream 10 random beats, out_ready toggling pseudo-randomly -> outputs in order, match the model, stable while stalled, in_ready low when full.
- Reset with 3 beats in flight -> out_valid 0 next cycle, all outputs 0, next accepted beat is the first emitted.
